// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the five-stage core's pipeline sequencing logic:
//   - state_t          : sequencing FSM states (INIT, RUN, MEM_WAIT)
//   - INIT_FLUSH_CYCLES: default number of forced-flush cycles after reset
//   - STALL_CNT_W      : default width of the stall statistics counter
//   - REG_ADDR_W       : register-file address width
//   - ctrl_word_t / BUBBLE_CTRL : control word carried by the pipeline
//     buffers and the all-zero bubble they load on a flush
// -----------------------------------------------------------------------------
package pipe_pkg;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    localparam int INIT_FLUSH_CYCLES = 3;
    localparam int STALL_CNT_W       = 16;
    localparam int REG_ADDR_W        = 3;

    // Control bits carried alongside each instruction through the buffers.
    typedef struct packed {
        logic reg_wr;
        logic mem_to_reg;
        logic mem_write;
        logic branch;
    } ctrl_word_t;

    // A bubble is an instruction whose control bits are all zero: it writes
    // nothing, reads no memory and never branches.
    localparam ctrl_word_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/hazard_detect.sv
// -----------------------------------------------------------------------------
// hazard_detect
// Purely combinational RAW / load-use compare between the instruction in
// decode and the writers further down the pipe.
//
// Build option: HAZARD_FORWARD_EN
//   defined   : forwarding unit present, only a load in execute whose
//               destination is read by decode causes a stall.
//   undefined : no forwarding, any register match against the execute or
//               memory-stage writer causes a stall.
//
// Ports:
//   id_rs1, id_rs2         decode source register addresses
//   id_use_rs1, id_use_rs2 decode instruction actually reads rs1 / rs2
//   ex_wr_en, ex_mem_read  execute-stage Regwr / MemtoReg
//   ex_wr_addr             execute-stage destination register
//   mem_wr_en, mem_wr_addr memory-stage Regwr / destination register
//   hazard                 decode must stall this cycle
// -----------------------------------------------------------------------------
module hazard_detect
    import pipe_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic                  ex_wr_en,
    input  logic                  ex_mem_read,
    input  logic [REG_ADDR_W-1:0] ex_wr_addr,
    input  logic                  mem_wr_en,
    input  logic [REG_ADDR_W-1:0] mem_wr_addr,
    output logic                  hazard
);

    // Register 0 is an ordinary register, so no zero-address masking.
    logic ex_match;
    assign ex_match = (id_use_rs1 && (id_rs1 == ex_wr_addr)) ||
                      (id_use_rs2 && (id_rs2 == ex_wr_addr));

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers every ALU result; only load data arrives too late.
    assign hazard = ex_wr_en && ex_mem_read && ex_match;

    logic unused_mem_writer;
    assign unused_mem_writer = ^{mem_wr_en, mem_wr_addr};
`else
    logic mem_match;
    assign mem_match = (id_use_rs1 && (id_rs1 == mem_wr_addr)) ||
                       (id_use_rs2 && (id_rs2 == mem_wr_addr));

    assign hazard = (ex_wr_en && ex_match) || (mem_wr_en && mem_match);

    logic unused_mem_read;
    assign unused_mem_read = ex_mem_read;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Pipeline sequencing controller for the five-stage core. Drives the PC
// enable and the enable/flush inputs of the F/D, D/E and E/M buffers.
// Handles post-reset clearing, RAW / load-use stalls, taken-branch squash and
// data-memory wait states. The buffers have no reset, so the INIT flush is
// what fills them with bubbles.
//
// Build option: HAZARD_FORWARD_EN (see hazard_detect).
//
// Parameters:
//   INIT_FLUSH_CYCLES  forced-flush cycles after reset release (1..15)
//   STALL_CNT_W        width of stall_cycles
// Ports:
//   clk, rst_n                 clock / async active-low reset
//   id_*                       decode-stage source operands
//   ex_wr_en, ex_mem_read,
//   ex_wr_addr                 execute-stage writer
//   mem_wr_en, mem_wr_addr     memory-stage writer
//   ex_branch_taken            branch resolved taken in execute
//   dmem_req, dmem_ready       data-memory handshake
//   pc_en, fd_en, de_en, em_en register enables (1 = load)
//   fd_flush, de_flush, em_flush load a bubble instead of the input
//   stall_cycles               saturating count of stalled cycles
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int INIT_FLUSH_CYCLES = pipe_pkg::INIT_FLUSH_CYCLES,
    parameter int STALL_CNT_W       = pipe_pkg::STALL_CNT_W
)(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_rs1,
    input  logic [REG_ADDR_W-1:0]  id_rs2,
    input  logic                   id_use_rs1,
    input  logic                   id_use_rs2,
    input  logic                   ex_wr_en,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_wr_addr,
    input  logic                   mem_wr_en,
    input  logic [REG_ADDR_W-1:0]  mem_wr_addr,
    input  logic                   ex_branch_taken,
    input  logic                   dmem_req,
    input  logic                   dmem_ready,
    output logic                   pc_en,
    output logic                   fd_en,
    output logic                   de_en,
    output logic                   em_en,
    output logic                   fd_flush,
    output logic                   de_flush,
    output logic                   em_flush,
    output logic [STALL_CNT_W-1:0] stall_cycles
);

    localparam logic [3:0] INIT_CNT_RST = 4'(INIT_FLUSH_CYCLES - 1);

    state_t     state;
    logic [3:0] init_cnt;
    logic       hazard;
    logic       mem_freeze;

    hazard_detect u_hazard_detect (
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_use_rs1  (id_use_rs1),
        .id_use_rs2  (id_use_rs2),
        .ex_wr_en    (ex_wr_en),
        .ex_mem_read (ex_mem_read),
        .ex_wr_addr  (ex_wr_addr),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_addr (mem_wr_addr),
        .hazard      (hazard)
    );

    // The freeze starts in the very cycle an unanswered request is seen, and
    // MEM_WAIT stays frozen even in the cycle dmem_ready arrives.
    assign mem_freeze = (state == MEM_WAIT) ||
                        ((state == RUN) && dmem_req && !dmem_ready);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of always-block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_cnt <= INIT_CNT_RST;
        end else begin
            case (state)
                INIT: begin
                    if (init_cnt == 4'd0) begin
                        state <= RUN;
                    end else begin
                        init_cnt <= init_cnt - 4'd1;
                    end
                end
                RUN: begin
                    if (dmem_req && !dmem_ready) begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    if (dmem_ready) begin
                        state <= RUN;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

    // Output priority: INIT flush > memory freeze > branch squash > hazard
    // stall > normal flow. A branch squashes the stalled instruction, so the
    // stall request is simply not honoured in that cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        pc_en    = 1'b1;
        fd_en    = 1'b1;
        de_en    = 1'b1;
        em_en    = 1'b1;
        fd_flush = 1'b0;
        de_flush = 1'b0;
        em_flush = 1'b0;
        if (state == INIT) begin
            pc_en    = 1'b0;
            fd_flush = 1'b1;
            de_flush = 1'b1;
            em_flush = 1'b1;
        end else if (mem_freeze) begin
            pc_en = 1'b0;
            fd_en = 1'b0;
            de_en = 1'b0;
            em_en = 1'b0;
        end else if (ex_branch_taken) begin
            fd_flush = 1'b1;
            de_flush = 1'b1;
        end else if (hazard) begin
            // Hold PC and F/D; push one bubble into D/E while E/M drains.
            pc_en    = 1'b0;
            fd_en    = 1'b0;
            de_flush = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (!pc_en && (state != INIT) && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage core. It drives the enable and flush inputs of the F/D, D/E and E/M buffers and the PC register. It handles four cases: post-reset pipeline clearing, load-use and RAW stalls, taken-branch squashing, and data-memory wait states. The pipeline buffers have no reset of their own, so this block is the only thing that puts them into a known, bubble-filled state.

## Interface
- INIT_FLUSH_CYCLES, 3: cycles of forced flush after reset deassertion (1..15).
- STALL_CNT_W, 16: width of the stall statistics counter.
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  3 each  source register addresses of the instruction in decode.
- id_use_rs1, id_use_rs2  in  1 each  decode instruction actually reads rs1 / rs2.
- ex_wr_en, ex_mem_read  in  1 each  D/E-buffer Regwr and MemtoReg of the instruction in execute.
- ex_wr_addr  in  3  D/E-buffer WriteAdd of the instruction in execute.
- mem_wr_en  in  1  E/M-buffer Regwr.
- mem_wr_addr  in  3  E/M-buffer write address.
- ex_branch_taken  in  1  branch resolved taken in execute.
- dmem_req, dmem_ready  in  1 each  data-memory request issued by the memory stage / request completed.
- pc_en, fd_en, de_en, em_en  out  1 each  register enables (1 = load).
- fd_flush, de_flush, em_flush  out  1 each  load a bubble (all control bits 0) instead of the input.
- stall_cycles  out  STALL_CNT_W  saturating count of stalled cycles.

## Operation
- FSM states:
  - INIT: reset state. Flush all buffers with PC held. Down-counter init_cnt runs from INIT_FLUSH_CYCLES-1. Leave INIT for RUN when init_cnt==0.
  - RUN: normal operation.
  - MEM_WAIT: entered from RUN when dmem_req=1 and dmem_ready=0. Return to RUN in the cycle after dmem_ready=1.
- Outputs are combinational from state and inputs. Priority is highest first:
  1. INIT: pc_en=0; fd_en, de_en, em_en=1; fd_flush, de_flush, em_flush=1.
  2. MEM_WAIT, or RUN with dmem_req & !dmem_ready: all enables 0, all flushes 0. The whole pipe is frozen, and ex_branch_taken is re-evaluated after unfreeze.
  3. ex_branch_taken: pc_en=1; fd_flush=1; de_flush=1; all enables 1. A stall request in the same cycle is discarded, because its instruction is squashed.
  4. Hazard, defined under Configuration: pc_en=0, fd_en=0, de_en=1, de_flush=1, em_en=1. Exactly one bubble is inserted per stalled cycle.
  5. Otherwise: all enables 1, all flushes 0.
- Register address 0 is a normal register. No special casing.
- stall_cycles increments when pc_en=0 and state≠INIT. It holds at all-ones.

## Timing
- Reset values (rst_n=0, asynchronous):
  - State is INIT and init_cnt=INIT_FLUSH_CYCLES-1.
  - stall_cycles=0.
  - Outputs: pc_en=0; fd_en, de_en, em_en=1; fd_flush, de_flush, em_flush=1.
- After rst_n rises, exactly INIT_FLUSH_CYCLES rising edges occur in INIT. pc_en first goes to 1 in the following cycle.
- The load-use stall lasts exactly 1 cycle, because the load then moves to the memory stage.
- The branch squash takes 1 cycle and costs 2 bubbles (F/D and D/E).
- MEM_WAIT freeze length is the dmem_ready latency.
  - dmem_ready=1 in the same cycle as dmem_req gives zero stall.
  - dmem_ready=1 in MEM_WAIT gives a freeze in that cycle too, with RUN on the next edge.
- rst_n asserted mid-stall or in MEM_WAIT: the block enters INIT immediately, and any pending branch or stall is dropped.

## Configuration
- HAZARD_FORWARD_EN defined: the forwarding unit is present. Hazard = ex_wr_en & ex_mem_read & ((id_use_rs1 & id_rs1==ex_wr_addr) | (id_use_rs2 & id_rs2==ex_wr_addr)).
- Not defined: no forwarding. Hazard = any RAW match, gated by id_use_rs1/id_use_rs2, against either of these writers:
  - the execute writer (ex_wr_en, ex_wr_addr), for any instruction type;
  - the memory writer (mem_wr_en, mem_wr_addr).
- Without the macro, a stall repeats each cycle until no match remains: up to 2 cycles per dependency.

## Structure
- A shared package pipe_pkg holds:
  - the FSM state enum (INIT, RUN, MEM_WAIT);
  - the default constants INIT_FLUSH_CYCLES and STALL_CNT_W;
  - the bubble control-word constant used by the buffers.
- One sub-module, hazard_detect: purely combinational RAW/load-use compare, with the HAZARD_FORWARD_EN split inside it. The FSM, counters and output priority live in the top module.

## Test plan
- Reset release with INIT_FLUSH_CYCLES=3 -> all flushes=1 and pc_en=0 for 3 edges; pc_en=1 and flushes=0 on the 4th cycle; stall_cycles=0.
- Load in execute writing r3 (ex_mem_read=1), decode reads r3 via rs2 -> one cycle of pc_en=0, fd_en=0, de_flush=1; next cycle normal; stall_cycles=1 (with HAZARD_FORWARD_EN).
- Same stimulus plus ex_branch_taken=1 -> pc_en=1, fd_flush=1, de_flush=1, no stall, stall_cycles unchanged.
- dmem_req=1 with dmem_ready low for 4 cycles -> all enables 0 for 4 cycles plus the ready cycle; then RUN; stall_cycles=5.
- Without HAZARD_FORWARD_EN: ALU op writing r5 in execute, decode reads r5 via rs1 -> 2 consecutive stall cycles, then proceed.
- rst_n pulsed low during MEM_WAIT -> outputs immediately take reset values; state INIT; stall_cycles=0.
